// File: rtl/regfile_wb_ctrl_if.sv
// Purpose: bundles the write-back requester handshakes, the ID scoreboard
//          query/claim signals and the register-file write port.
// Ports:   slave = write-back controller side, master = pipeline/requester side.
interface regfile_wb_ctrl_if #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
);
    // ALU result requester
    logic            valid_ALU_i;
    logic [AW-1:0]   addr_ALU_i;
    logic [DW-1:0]   data_ALU_i;
    logic            ready_ALU_o;
    // load/store requester
    logic            valid_LSU_i;
    logic [AW-1:0]   addr_LSU_i;
    logic [DW-1:0]   data_LSU_i;
    logic            ready_LSU_o;
    // ID stage scoreboard claim and hazard query
    logic            claim_ID_i;
    logic [AW-1:0]   claim_addr_ID_i;
    logic [AW-1:0]   raddr1_ID_i;
    logic [AW-1:0]   raddr2_ID_i;
    logic            re1_ID_i;
    logic            re2_ID_i;
    logic            stall_ID_o;
    logic            flush_i;
    // register file write port and debug
    logic            we_REG_o;
    logic [AW-1:0]   waddr_REG_o;
    logic [DW-1:0]   wdata_REG_o;
    logic [NREG-1:0] busy_o;

    modport slave (
        input  valid_ALU_i, addr_ALU_i, data_ALU_i,
        input  valid_LSU_i, addr_LSU_i, data_LSU_i,
        input  claim_ID_i, claim_addr_ID_i, raddr1_ID_i, raddr2_ID_i,
        input  re1_ID_i, re2_ID_i, flush_i,
        output ready_ALU_o, ready_LSU_o, stall_ID_o,
        output we_REG_o, waddr_REG_o, wdata_REG_o, busy_o
    );

    modport master (
        output valid_ALU_i, addr_ALU_i, data_ALU_i,
        output valid_LSU_i, addr_LSU_i, data_LSU_i,
        output claim_ID_i, claim_addr_ID_i, raddr1_ID_i, raddr2_ID_i,
        output re1_ID_i, re2_ID_i, flush_i,
        input  ready_ALU_o, ready_LSU_o, stall_ID_o,
        input  we_REG_o, waddr_REG_o, wdata_REG_o, busy_o
    );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// Purpose: round-robin arbiter of ALU/LSU write-backs onto the single register
//          file write port, plus a per-register busy scoreboard driving ID stalls.
// Latency: 1 cycle from accepted request to we_REG_o; ready/stall are combinational.
// Backpressure: at most one ready per cycle; the loser holds its request until granted.
// Ports: dclk (clock), rst (async active-low reset), bus (regfile_wb_ctrl_if.slave).
module regfile_wb_ctrl #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic dclk,
    input  logic rst,
    regfile_wb_ctrl_if.slave bus
);
    // r_ptr: 0 = ALU wins the next contested cycle, 1 = LSU wins
    logic            r_ptr;
    logic            r_we;
    logic [AW-1:0]   r_waddr;
    logic [DW-1:0]   r_wdata;
    logic [NREG-1:0] r_busy;

    logic            w_gnt_alu;
    logic            w_gnt_lsu;
    logic            w_gnt;
    logic            w_contested;
    logic [AW-1:0]   w_gaddr;
    logic [DW-1:0]   w_gdata;
    logic            w_wr;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;
    logic [NREG-1:0] w_busy_nxt;
    logic            w_hit1;
    logic            w_hit2;

    // Grants are masked by reset so no handshake completes while held in reset.
    assign w_gnt_alu   = rst && bus.valid_ALU_i && (!bus.valid_LSU_i || !r_ptr);
    assign w_gnt_lsu   = rst && bus.valid_LSU_i && (!bus.valid_ALU_i ||  r_ptr);
    assign w_gnt       = w_gnt_alu || w_gnt_lsu;
    assign w_contested = rst && bus.valid_ALU_i && bus.valid_LSU_i;
    assign w_gaddr     = w_gnt_lsu ? bus.addr_LSU_i : bus.addr_ALU_i;
    assign w_gdata     = w_gnt_lsu ? bus.data_LSU_i : bus.data_ALU_i;
    // x0 grants complete the handshake but never reach the register file.
    assign w_wr        = w_gnt && (w_gaddr != '0);

    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (bus.claim_ID_i && (bus.claim_addr_ID_i != '0)) begin
            w_set[bus.claim_addr_ID_i] = 1'b1;
        end
        if (w_wr) begin
            w_clr[w_gaddr] = 1'b1;
        end
        // Set is applied after clear so a same-cycle claim keeps the bit busy.
        w_busy_nxt = bus.flush_i ? '0 : ((r_busy & ~w_clr) | w_set);
    end

    // The bit is cleared when the output register loads, but the register file
    // only commits one edge later, so the in-flight write still counts as busy.
    assign w_hit1 = bus.re1_ID_i && (bus.raddr1_ID_i != '0) &&
                    (r_busy[bus.raddr1_ID_i] || (r_we && (r_waddr == bus.raddr1_ID_i)));
    assign w_hit2 = bus.re2_ID_i && (bus.raddr2_ID_i != '0) &&
                    (r_busy[bus.raddr2_ID_i] || (r_we && (r_waddr == bus.raddr2_ID_i)));

    always_ff @(posedge dclk or negedge rst) begin
        if (!rst) begin
            r_ptr   <= 1'b0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_busy  <= '0;
        end else begin
            r_we   <= w_wr;
            r_busy <= w_busy_nxt;
            if (w_wr) begin
                r_waddr <= w_gaddr;
                r_wdata <= w_gdata;
            end
            if (w_contested) begin
                r_ptr <= ~r_ptr;
            end
        end
    end

    assign bus.ready_ALU_o = w_gnt_alu;
    assign bus.ready_LSU_o = w_gnt_lsu;
    assign bus.stall_ID_o  = w_hit1 || w_hit2;
    assign bus.we_REG_o    = r_we;
    assign bus.waddr_REG_o = r_waddr;
    assign bus.wdata_REG_o = r_wdata;
    assign bus.busy_o      = r_busy;
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Purpose: directed self-checking bench for regfile_wb_ctrl.
// Inputs change on the falling edge; outputs are sampled 1 time unit later,
// so registered results of a rising edge are seen at the following falling edge.
module tb_regfile_wb_ctrl;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic dclk;
    logic rst;
    int   total;
    int   bad;

    regfile_wb_ctrl_if #(.NREG(NREG), .AW(AW), .DW(DW)) bus ();

    regfile_wb_ctrl #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
        .dclk (dclk),
        .rst  (rst),
        .bus  (bus.slave)
    );

    initial dclk = 1'b0;
    always #5 dclk = ~dclk;

    task automatic idle_inputs();
        bus.valid_ALU_i     = 1'b0;
        bus.addr_ALU_i      = '0;
        bus.data_ALU_i      = '0;
        bus.valid_LSU_i     = 1'b0;
        bus.addr_LSU_i      = '0;
        bus.data_LSU_i      = '0;
        bus.claim_ID_i      = 1'b0;
        bus.claim_addr_ID_i = '0;
        bus.raddr1_ID_i     = '0;
        bus.raddr2_ID_i     = '0;
        bus.re1_ID_i        = 1'b0;
        bus.re2_ID_i        = 1'b0;
        bus.flush_i         = 1'b0;
    endtask

    task automatic next_cycle();
        @(negedge dclk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        bus.valid_ALU_i = 1'b1;
        bus.addr_ALU_i  = 5'd2;
        repeat (3) @(negedge dclk);
        #1;
        total++; if (bus.ready_ALU_o !== 1'b0) begin bad++; $display("FAIL reset_ready_alu got=%b exp=0", bus.ready_ALU_o); end
        total++; if (bus.we_REG_o !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", bus.we_REG_o); end
        idle_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        total++; if (bus.we_REG_o !== 1'b0) begin bad++; $display("FAIL idle_we got=%b exp=0", bus.we_REG_o); end
        total++; if (bus.waddr_REG_o !== 5'd0 || bus.wdata_REG_o !== 32'd0) begin bad++; $display("FAIL idle_wport got=%0d/%h exp=0/0", bus.waddr_REG_o, bus.wdata_REG_o); end
        total++; if (bus.busy_o !== 32'd0) begin bad++; $display("FAIL idle_busy got=%h exp=0", bus.busy_o); end
        total++; if (bus.ready_ALU_o !== 1'b0 || bus.ready_LSU_o !== 1'b0) begin bad++; $display("FAIL idle_ready got=%b%b exp=00", bus.ready_ALU_o, bus.ready_LSU_o); end
        total++; if (bus.stall_ID_o !== 1'b0) begin bad++; $display("FAIL idle_stall got=%b exp=0", bus.stall_ID_o); end
    endtask

    task automatic test_alu_only();
        @(negedge dclk);
        bus.valid_ALU_i = 1'b1;
        bus.addr_ALU_i  = 5'd5;
        bus.data_ALU_i  = 32'hDEADBEEF;
        #1;
        total++; if (bus.ready_ALU_o !== 1'b1 || bus.ready_LSU_o !== 1'b0) begin bad++; $display("FAIL alu_ready got=%b%b exp=10", bus.ready_ALU_o, bus.ready_LSU_o); end
        @(negedge dclk);
        idle_inputs();
        #1;
        total++; if (bus.we_REG_o !== 1'b1 || bus.waddr_REG_o !== 5'd5 || bus.wdata_REG_o !== 32'hDEADBEEF)
            begin bad++; $display("FAIL alu_write got=%b/%0d/%h exp=1/5/deadbeef", bus.we_REG_o, bus.waddr_REG_o, bus.wdata_REG_o); end
        next_cycle();
        total++; if (bus.we_REG_o !== 1'b0 || bus.waddr_REG_o !== 5'd5 || bus.wdata_REG_o !== 32'hDEADBEEF)
            begin bad++; $display("FAIL alu_after got=%b/%0d/%h exp=0/5/deadbeef", bus.we_REG_o, bus.waddr_REG_o, bus.wdata_REG_o); end
    endtask

    task automatic test_contention();
        // Pointer starts ALU-preferred and flips on every contested cycle.
        logic       exp_alu [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [4:0] exp_addr [4] = '{5'd3, 5'd4, 5'd3, 5'd4};
        logic [31:0] exp_data [4] = '{32'hA0000003, 32'hB0000004, 32'hA0000003, 32'hB0000004};
        @(negedge dclk);
        bus.valid_ALU_i = 1'b1; bus.addr_ALU_i = 5'd3; bus.data_ALU_i = 32'hA0000003;
        bus.valid_LSU_i = 1'b1; bus.addr_LSU_i = 5'd4; bus.data_LSU_i = 32'hB0000004;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (bus.ready_ALU_o !== exp_alu[i] || bus.ready_LSU_o !== !exp_alu[i])
                begin bad++; $display("FAIL contend_ready[%0d] got=%b%b exp=%b%b", i, bus.ready_ALU_o, bus.ready_LSU_o, exp_alu[i], !exp_alu[i]); end
            @(negedge dclk);
            if (i == 3) idle_inputs();
            #1;
            total++; if (bus.we_REG_o !== 1'b1 || bus.waddr_REG_o !== exp_addr[i] || bus.wdata_REG_o !== exp_data[i])
                begin bad++; $display("FAIL contend_write[%0d] got=%b/%0d/%h exp=1/%0d/%h", i, bus.we_REG_o, bus.waddr_REG_o, bus.wdata_REG_o, exp_addr[i], exp_data[i]); end
        end
        next_cycle();
    endtask

    task automatic test_scoreboard();
        @(negedge dclk);
        bus.claim_ID_i = 1'b1; bus.claim_addr_ID_i = 5'd7;
        @(negedge dclk);
        bus.claim_ID_i = 1'b0;
        bus.re1_ID_i = 1'b1; bus.raddr1_ID_i = 5'd7;
        #1;
        total++; if (bus.busy_o !== 32'h0000_0080) begin bad++; $display("FAIL sb_claim got=%h exp=00000080", bus.busy_o); end
        total++; if (bus.stall_ID_o !== 1'b1) begin bad++; $display("FAIL sb_stall_busy got=%b exp=1", bus.stall_ID_o); end
        bus.valid_LSU_i = 1'b1; bus.addr_LSU_i = 5'd7; bus.data_LSU_i = 32'h0000_0077;
        #1;
        total++; if (bus.ready_LSU_o !== 1'b1 || bus.stall_ID_o !== 1'b1) begin bad++; $display("FAIL sb_lsu_grant got=%b/%b exp=1/1", bus.ready_LSU_o, bus.stall_ID_o); end
        @(negedge dclk);
        bus.valid_LSU_i = 1'b0;
        #1;
        total++; if (bus.busy_o !== 32'd0 || bus.we_REG_o !== 1'b1 || bus.waddr_REG_o !== 5'd7)
            begin bad++; $display("FAIL sb_clear got=%h/%b/%0d exp=0/1/7", bus.busy_o, bus.we_REG_o, bus.waddr_REG_o); end
        total++; if (bus.stall_ID_o !== 1'b1) begin bad++; $display("FAIL sb_stall_inflight got=%b exp=1", bus.stall_ID_o); end
        next_cycle();
        total++; if (bus.stall_ID_o !== 1'b0) begin bad++; $display("FAIL sb_stall_done got=%b exp=0", bus.stall_ID_o); end
        // Claim of x0 is ignored; a reg read via port 2 stalls only when enabled.
        bus.claim_ID_i = 1'b1; bus.claim_addr_ID_i = 5'd0;
        @(negedge dclk);
        bus.claim_ID_i = 1'b1; bus.claim_addr_ID_i = 5'd12;
        #1;
        total++; if (bus.busy_o !== 32'd0) begin bad++; $display("FAIL sb_x0_claim got=%h exp=0", bus.busy_o); end
        @(negedge dclk);
        bus.claim_ID_i = 1'b0;
        bus.re1_ID_i = 1'b1; bus.raddr1_ID_i = 5'd0;
        bus.re2_ID_i = 1'b1; bus.raddr2_ID_i = 5'd12;
        #1;
        total++; if (bus.stall_ID_o !== 1'b1) begin bad++; $display("FAIL sb_stall_src2 got=%b exp=1", bus.stall_ID_o); end
        bus.re2_ID_i = 1'b0;
        #1;
        total++; if (bus.stall_ID_o !== 1'b0) begin bad++; $display("FAIL sb_src2_disabled got=%b exp=0", bus.stall_ID_o); end
        idle_inputs();
        bus.flush_i = 1'b1;
        next_cycle();
        bus.flush_i = 1'b0;
    endtask

    task automatic test_claim_clear_flush();
        @(negedge dclk);
        bus.valid_ALU_i = 1'b1; bus.addr_ALU_i = 5'd9; bus.data_ALU_i = 32'h0000_0099;
        bus.claim_ID_i = 1'b1; bus.claim_addr_ID_i = 5'd9;
        @(negedge dclk);
        bus.claim_ID_i = 1'b1; bus.claim_addr_ID_i = 5'd10;
        bus.valid_ALU_i = 1'b1; bus.addr_ALU_i = 5'd11; bus.data_ALU_i = 32'h0000_000B;
        bus.flush_i = 1'b1;
        #1;
        total++; if (bus.busy_o !== 32'h0000_0200) begin bad++; $display("FAIL cc_claim_wins got=%h exp=00000200", bus.busy_o); end
        total++; if (bus.we_REG_o !== 1'b1 || bus.waddr_REG_o !== 5'd9) begin bad++; $display("FAIL cc_write got=%b/%0d exp=1/9", bus.we_REG_o, bus.waddr_REG_o); end
        @(negedge dclk);
        idle_inputs();
        #1;
        total++; if (bus.busy_o !== 32'd0) begin bad++; $display("FAIL flush_busy got=%h exp=0", bus.busy_o); end
        total++; if (bus.we_REG_o !== 1'b1 || bus.waddr_REG_o !== 5'd11 || bus.wdata_REG_o !== 32'h0000_000B)
            begin bad++; $display("FAIL flush_write got=%b/%0d/%h exp=1/11/0000000b", bus.we_REG_o, bus.waddr_REG_o, bus.wdata_REG_o); end
        next_cycle();
    endtask

    task automatic test_x0_write();
        @(negedge dclk);
        bus.claim_ID_i = 1'b1; bus.claim_addr_ID_i = 5'd3;
        @(negedge dclk);
        bus.claim_ID_i = 1'b0;
        bus.valid_ALU_i = 1'b1; bus.addr_ALU_i = 5'd0; bus.data_ALU_i = 32'h0000_1234;
        #1;
        total++; if (bus.ready_ALU_o !== 1'b1) begin bad++; $display("FAIL x0_ready got=%b exp=1", bus.ready_ALU_o); end
        @(negedge dclk);
        idle_inputs();
        #1;
        total++; if (bus.we_REG_o !== 1'b0) begin bad++; $display("FAIL x0_we got=%b exp=0", bus.we_REG_o); end
        total++; if (bus.waddr_REG_o !== 5'd11 || bus.wdata_REG_o !== 32'h0000_000B)
            begin bad++; $display("FAIL x0_hold got=%0d/%h exp=11/0000000b", bus.waddr_REG_o, bus.wdata_REG_o); end
        total++; if (bus.busy_o !== 32'h0000_0008) begin bad++; $display("FAIL x0_busy got=%h exp=00000008", bus.busy_o); end
    endtask

    task automatic test_reset_mid();
        // Contested grant moves the pointer to LSU and loads a pending write.
        @(negedge dclk);
        bus.valid_ALU_i = 1'b1; bus.addr_ALU_i = 5'd6; bus.data_ALU_i = 32'h0000_0066;
        bus.valid_LSU_i = 1'b1; bus.addr_LSU_i = 5'd8; bus.data_LSU_i = 32'h0000_0088;
        bus.claim_ID_i = 1'b1; bus.claim_addr_ID_i = 5'd5;
        @(negedge dclk);
        idle_inputs();
        #1;
        total++; if (bus.we_REG_o !== 1'b1 || bus.waddr_REG_o !== 5'd6) begin bad++; $display("FAIL mid_pending got=%b/%0d exp=1/6", bus.we_REG_o, bus.waddr_REG_o); end
        rst = 1'b0;
        #1;
        total++; if (bus.we_REG_o !== 1'b0 || bus.waddr_REG_o !== 5'd0 || bus.wdata_REG_o !== 32'd0 || bus.busy_o !== 32'd0)
            begin bad++; $display("FAIL mid_reset got=%b/%0d/%h/%h exp=0/0/0/0", bus.we_REG_o, bus.waddr_REG_o, bus.wdata_REG_o, bus.busy_o); end
        @(negedge dclk);
        rst = 1'b1;
        @(negedge dclk);
        bus.valid_ALU_i = 1'b1; bus.addr_ALU_i = 5'd6;
        bus.valid_LSU_i = 1'b1; bus.addr_LSU_i = 5'd8;
        #1;
        total++; if (bus.ready_ALU_o !== 1'b1 || bus.ready_LSU_o !== 1'b0)
            begin bad++; $display("FAIL mid_ptr_reset got=%b%b exp=10", bus.ready_ALU_o, bus.ready_LSU_o); end
        @(negedge dclk);
        idle_inputs();
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_alu_only();
        test_contention();
        test_scoreboard();
        test_claim_clear_flush();
        test_x0_write();
        test_reset_mid();
        repeat (2) @(negedge dclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
